ram_req_arbiter: RTL and testbench
==================================

# ram_req_arbiter

Initiator-side front end for one port of the dual-port data RAM. Two core-side requesters (valid/ready) share one RAM access port. The block arbitrates between them, registers the command and drives the RAM port signals. It then captures the one-cycle-latency read data and returns a response to the granted requester. One transaction is in flight at a time; a second RAM port is served by a second instance.

## Interface
Parameters:
- WORD, 16: data width in bits.
- ADDR_W, 8: RAM word-address width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester accept; one-hot or zero.
- req_addr_i  in  2×ADDR_W  per-requester word address.
- req_wdata_i  in  2×WORD  per-requester write data.
- req_write_i  in  2  per-requester write (1) / read (0).
- rsp_valid_o  out  2  per-requester response valid; one-hot or zero.
- rsp_ready_i  in  2  per-requester response accept.
- rsp_rdata_o  out  WORD  read data, shared; 0 for writes.
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  WORD  RAM write data.
- ram_write_o  out  1  RAM write strobe.
- ram_rdata_i  in  WORD  RAM registered read data.

## Operation
- FSM states: IDLE, CMD, CAPT, RSP. Reset state is IDLE.
- IDLE: req_ready_o is high for the granted requester only. A handshake on that requester registers addr, wdata, write and the requester id, then goes to CMD. With no valid request, stay in IDLE.
- Grant: with one requester valid, grant it. With both valid, grant per Configuration.
- CMD: ram_en_o is 1, ram_addr_o/ram_wdata_o carry the registered command, ram_write_o equals the registered write bit. Goes to CAPT unconditionally.
- CAPT: ram_en_o is 0. At the end of the cycle, capture ram_rdata_i into rsp_rdata_o for reads, or 0 for writes. Goes to RSP.
- RSP: rsp_valid_o[id] is 1, and the response holds stable until rsp_ready_i[id]. On the handshake, go to IDLE.
- rsp_ready_i of the non-owning requester is ignored.
- Requesters hold request fields stable while valid and not ready. The block does not check this.
- All outputs are registered.

## Timing
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, ram_en_o=0, ram_addr_o=0, ram_wdata_o=0, ram_write_o=0. The round-robin pointer resets to favour requester 0.
- req_ready_o rises in the first cycle after rst deasserts when any request is valid.
- Accept in cycle T → CMD in T+1 → CAPT in T+2 → rsp_valid_o high from T+3.
- With rsp_ready_i held high, the response handshake is in T+3, IDLE is in T+4, and the next accept can be in T+4. Throughput is one transaction per 4 cycles.
- Back-to-back requests from the same requester are never accepted before its response handshake.
- Reset asserted during CMD: the RAM still samples the command at that edge, so a write lands. No response is issued and the state is IDLE after reset.
- Reset during CAPT/RSP: the response is discarded.
- Address and data are passed through with no arithmetic or wrap. The full ADDR_W range is legal.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: with both requesters valid in IDLE, grant the requester not granted last. The pointer updates on each accept.
- RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins, and no pointer register exists.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, CMD, CAPT, RSP);
  - a request struct (addr, wdata, write) parameterised by the WORD/ADDR_W defaults;
  - the requester-count constant (2).
- Sub-module arb2_grant: two-input grant logic, with a pointer register under RAM_ARB_ROUND_ROBIN_EN. It outputs a one-hot grant.

## Test plan
- Write from requester 0: addr 0x12, data 0xBEEF. Then read 0x12 from requester 1 → the RAM sees ram_write_o=1 in T+1 of the write. The read response is 0xBEEF on rsp_valid_o=2'b10 at T+3.
- Both valid continuously, round-robin build → grants alternate 0,1,0,1 across 4 transactions. Fixed-priority build → requester 0 wins all 4.
- rsp_ready_i held low for 5 cycles in RSP → rsp_valid_o and rsp_rdata_o are stable for all 5 cycles, and req_ready_o stays 2'b00.
- Read of addr 0xFF (max) after writing 0x0001 → returns 0x0001. Read of an unwritten location after reset → returns 0x0000.
- rst pulsed during CMD of a write of 0x00AA to 0x05 → no rsp_valid_o. A later read of 0x05 returns 0x00AA. All outputs are at reset values the cycle after rst.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM request arbiter.
// Holds the FSM state encoding, the default-width request record and the
// requester count used by ram_req_arbiter and arb2_grant.
package ram_arb_pkg;

    localparam int N_REQ      = 2;
    localparam int WORD_DEF   = 16;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_CAPT = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [WORD_DEF-1:0]   wdata;
        logic                  write;
    } req_t;

endpackage

// File: rtl/arb2_grant.sv
// arb2_grant: two-input grant logic producing a one-hot (or zero) grant.
// Build option RAM_ARB_ROUND_ROBIN_EN: when defined, a one-bit pointer makes
// the requester not granted last win a tie; when undefined, requester 0 wins
// every tie and no pointer register exists.
module arb2_grant
    import ram_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] valid_i,
    input  logic             accept_i,
    input  logic             accept_id_i,
    output logic [N_REQ-1:0] grant_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // prio_q = 1 means requester 1 wins the next tie
    logic prio_q, prio_d;

    // Point at the other requester after every accept
    always_comb begin
        prio_d = prio_q;
        if (accept_i) begin
            prio_d = ~accept_id_i;
        end
    end

    // Pointer register, reset to favour requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Single valid requester wins outright; ties resolved by the pointer
    always_comb begin
        grant_o = '0;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
            default: grant_o = '0;
        endcase
    end
`else
    // Fixed priority needs no state; these inputs are intentionally unused
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, accept_i, accept_id_i};

    // Requester 0 always wins; requester 1 only when 0 is idle
    always_comb begin
        grant_o = '0;
        if (valid_i[0]) begin
            grant_o = 2'b01;
        end else if (valid_i[1]) begin
            grant_o = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/ram_req_arbiter.sv
// ram_req_arbiter: front end that lets two valid/ready requesters share one
// RAM port. One transaction in flight: IDLE -> CMD -> CAPT -> RSP -> IDLE.
// All outputs are registered. Build option RAM_ARB_ROUND_ROBIN_EN selects
// round-robin tie breaking in arb2_grant (default: requester 0 priority).
module ram_req_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORD   = 16,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*WORD-1:0]   req_wdata_i,
    input  logic [N_REQ-1:0]        req_write_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    input  logic [N_REQ-1:0]        rsp_ready_i,
    output logic [WORD-1:0]         rsp_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_W-1:0]       ram_addr_o,
    output logic [WORD-1:0]         ram_wdata_o,
    output logic                    ram_write_o,
    input  logic [WORD-1:0]         ram_rdata_i
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [WORD-1:0]    rsp_rdata_q;
    logic               ram_en_q;
    logic               ram_write_q;
    logic [ADDR_W-1:0]  ram_addr_q;
    logic [WORD-1:0]    ram_wdata_q;
    logic               cmd_write_q;
    logic               id_q;

    logic [N_REQ-1:0]   grant;
    logic               accept;
    logic               acc_id;
    logic               rsp_done;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WORD-1:0]    sel_wdata;
    logic               sel_write;

    // req_ready_q is one-hot in IDLE, so its upper bit names the accepted requester
    assign acc_id    = req_ready_q[1];
    assign accept    = (state_q == ST_IDLE) && ((req_valid_i & req_ready_q) != '0);
    assign rsp_done  = (state_q == ST_RSP) && rsp_ready_i[id_q];

    assign sel_addr  = acc_id ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
    assign sel_wdata = acc_id ? req_wdata_i[2*WORD-1:WORD]    : req_wdata_i[WORD-1:0];
    assign sel_write = req_write_i[acc_id];

    arb2_grant u_grant (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (req_valid_i),
        .accept_i    (accept),
        .accept_id_i (acc_id),
        .grant_o     (grant)
    );

    // Next state and next ready; ready is decided one cycle ahead so it can be registered
    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CMD;
                end else begin
                    req_ready_d = grant;
                end
            end
            ST_CMD:  state_d = ST_CAPT;
            ST_CAPT: state_d = ST_RSP;
            ST_RSP: begin
                if (rsp_done) begin
                    state_d     = ST_IDLE;
                    req_ready_d = grant;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, command registers, RAM drive and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            ram_en_q    <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cmd_write_q <= 1'b0;
            id_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            // RAM enable and strobe are high only in the CMD cycle
            ram_en_q    <= accept;
            ram_write_q <= accept & sel_write;
            if (accept) begin
                ram_addr_q  <= sel_addr;
                ram_wdata_q <= sel_wdata;
                cmd_write_q <= sel_write;
                id_q        <= acc_id;
            end
            if (state_q == ST_CAPT) begin
                rsp_rdata_q <= cmd_write_q ? '0 : ram_rdata_i;
                rsp_valid_q <= {id_q, ~id_q};
            end else if (rsp_done) begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign ram_en_o    = ram_en_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_write_o = ram_write_q;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb_ram_req_arbiter: randomized and directed stimulus for ram_req_arbiter,
// checked cycle by cycle against a transaction-level model (golden memory,
// expected grant rule, fixed command/response latencies).
module tb_ram_req_arbiter;
    import ram_arb_pkg::*;

    localparam int WORD   = 16;
    localparam int ADDR_W = 8;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              req_valid, req_ready, req_write;
    logic [2*ADDR_W-1:0]     req_addr;
    logic [2*WORD-1:0]       req_wdata;
    logic [1:0]              rsp_valid, rsp_ready;
    logic [WORD-1:0]         rsp_rdata;
    logic                    ram_en, ram_write;
    logic [ADDR_W-1:0]       ram_addr;
    logic [WORD-1:0]         ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_req_arbiter #(.WORD(WORD), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_write_i (req_write),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_write_o (ram_write),
        .ram_rdata_i (ram_rdata)
    );

    // Behavioural single-port RAM with one-cycle registered read
    logic [WORD-1:0] ram_mem [256];
    logic            mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_write) ram_mem[ram_addr] <= ram_wdata;
            else           ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Model state
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [WORD-1:0] gold [256];
    req_t            q0[$];
    req_t            q1[$];
    req_t            cur [2];
    logic [1:0]      vld, acc_last, dec_valid;
    bit              busy, prev_dec, last_gnt, was_rst, cur_id;
    int              age;
    req_t            cur_tx;
    logic [WORD-1:0] cur_exp, last_rd_act;
    int              gnt_log[$];
    int              gate_mode, rsp_mode, hold_left, rsp_cycles;
    bit              rst_req, rst_at_cmd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected grant from the valid vector seen in the decision cycle
    function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit last);
        if (v == 2'b11) return RR_EN ? (last ? 2'b01 : 2'b10) : 2'b01;
        return v;
    endfunction

    function automatic req_t mk_op(input logic [7:0] a, input logic [15:0] d, input logic w);
        req_t t;
        t.addr = a; t.wdata = d; t.write = w;
        return t;
    endfunction

    function automatic req_t rand_op();
        req_t t;
        t.write = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0:       t.addr = 8'hFF;
            1:       t.addr = 8'h00;
            default: t.addr = 8'($urandom_range(0, 15));
        endcase
        t.wdata = 16'($urandom);
        return t;
    endfunction

    // One clock: check outputs at the negedge, then drive inputs for the next posedge
    task automatic step();
        logic [1:0] hs;
        bit         rsp_done, busy_before, do_rst;
        @(negedge clk);
        if (was_rst) begin
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_rsp_rdata", rsp_rdata, 0);
            check_eq("rst_ram_en", ram_en, 0);
            check_eq("rst_ram_addr", ram_addr, 0);
            check_eq("rst_ram_wdata", ram_wdata, 0);
            check_eq("rst_ram_write", ram_write, 0);
        end else begin
            if (busy) age++;
            check_eq("req_ready", req_ready, prev_dec ? exp_grant(dec_valid, last_gnt) : 2'b00);
            if (busy && age == 1) begin
                check_eq("cmd_ram_en", ram_en, 1);
                check_eq("cmd_ram_addr", ram_addr, cur_tx.addr);
                check_eq("cmd_ram_wdata", ram_wdata, cur_tx.wdata);
                check_eq("cmd_ram_write", ram_write, cur_tx.write);
            end else begin
                check_eq("ram_en_low", ram_en, 0);
                check_eq("ram_write_low", ram_write, 0);
            end
            if (busy && age >= 3) begin
                rsp_cycles++;
                check_eq("rsp_valid", rsp_valid, cur_id ? 2'b10 : 2'b01);
                check_eq("rsp_rdata", rsp_rdata, cur_exp);
            end else begin
                check_eq("rsp_valid_low", rsp_valid, 0);
            end
        end

        do_rst = rst_req;
        if (rst_at_cmd && busy && age == 1 && !was_rst) begin
            do_rst     = 1'b1;
            rst_at_cmd = 1'b0;
        end

        for (int r = 0; r < 2; r++) begin
            if (vld[r] && acc_last[r]) vld[r] = 1'b0;
            if (!vld[r] && (gate_mode == 1 || $urandom_range(0, 1) == 1)) begin
                if (r == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); vld[0] = 1'b1; end
                if (r == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); vld[1] = 1'b1; end
            end
            if (!vld[r]) cur[r] = rand_op();
        end
        rst       = do_rst;
        req_valid = vld;
        req_addr  = {cur[1].addr, cur[0].addr};
        req_wdata = {cur[1].wdata, cur[0].wdata};
        req_write = {cur[1].write, cur[0].write};
        if (rsp_mode == 1) begin
            rsp_ready = 2'b11;
        end else if (rsp_mode == 2) begin
            if (busy && age >= 3 && hold_left > 0) begin
                rsp_ready = cur_id ? 2'b01 : 2'b10;
                hold_left--;
            end else begin
                rsp_ready = 2'b11;
            end
        end else begin
            rsp_ready = 2'($urandom_range(0, 3));
        end

        was_rst  = do_rst;
        acc_last = 2'b00;
        if (do_rst) begin
            prev_dec = 1'b0;
            busy     = 1'b0;
            age      = 0;
            last_gnt = 1'b1;
        end else begin
            hs          = req_ready & vld;
            busy_before = busy;
            rsp_done    = busy && age >= 3 && rsp_ready[cur_id];
            if (rsp_done) begin
                last_rd_act = rsp_rdata;
                busy        = 1'b0;
            end
            prev_dec  = (!busy_before && hs == 2'b00) || rsp_done;
            dec_valid = vld;
            if (hs != 2'b00) begin
                cur_id  = hs[1];
                cur_tx  = cur[hs[1]];
                cur_exp = cur_tx.write ? 16'h0000 : gold[cur_tx.addr];
                if (cur_tx.write) gold[cur_tx.addr] = cur_tx.wdata;
                busy     = 1'b1;
                age      = 0;
                last_gnt = hs[1];
                gnt_log.push_back(int'(hs[1]));
                acc_last = hs;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || vld != 2'b00 || q0.size() > 0 || q1.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("idle_timeout", (busy || vld != 2'b00) ? 1 : 0, 0);
        step();
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = '0; req_addr = '0; req_wdata = '0; req_write = '0; rsp_ready = '0;
        vld = '0; acc_last = '0; dec_valid = '0;
        busy = 0; prev_dec = 0; last_gnt = 1; was_rst = 1; cur_id = 0; age = 0;
        gate_mode = 1; rsp_mode = 1; hold_left = 0; rsp_cycles = 0;
        rst_req = 1; rst_at_cmd = 0;
        last_rd_act = '0;
        for (int i = 0; i < 256; i++) gold[i] = '0;
        cur[0] = mk_op(8'h00, 16'h0000, 1'b0);
        cur[1] = mk_op(8'h00, 16'h0000, 1'b0);
        cur_tx = cur[0]; cur_exp = '0;

        repeat (3) step();
        rst_req = 0; mem_clr = 1'b0;
        step();

        // Unwritten location after reset reads zero
        last_rd_act = 16'hDEAD;
        q0.push_back(mk_op(8'h80, 16'h1234, 1'b0));
        wait_idle(50);
        check_eq("unwritten_rd", last_rd_act, 16'h0000);

        // Write from 0, read back from 1
        q0.push_back(mk_op(8'h12, 16'hBEEF, 1'b1));
        wait_idle(50);
        last_rd_act = 16'hDEAD;
        q1.push_back(mk_op(8'h12, 16'h0000, 1'b0));
        wait_idle(50);
        check_eq("wr_rd_beef", last_rd_act, 16'hBEEF);

        // Max address
        q0.push_back(mk_op(8'hFF, 16'h0001, 1'b1));
        q0.push_back(mk_op(8'hFF, 16'h0000, 1'b0));
        wait_idle(50);
        check_eq("max_addr_rd", last_rd_act, 16'h0001);

        // Response back-pressure for 5 cycles (requester 1, leaves last grant = 1)
        rsp_mode = 2; hold_left = 5; rsp_cycles = 0;
        q1.push_back(mk_op(8'h12, 16'h0000, 1'b0));
        wait_idle(50);
        check_eq("rsp_hold_cycles", rsp_cycles, 6);
        check_eq("rsp_hold_data", last_rd_act, 16'hBEEF);
        rsp_mode = 1;

        // Both requesters continuously valid
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk_op(8'(8'h40 + i), 16'(16'h0A00 + i), 1'b1));
            q1.push_back(mk_op(8'(8'h50 + i), 16'(16'h0B00 + i), 1'b1));
        end
        wait_idle(200);
        check_eq("grant_count", gnt_log.size(), 8);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("grant_%0d", i), gnt_log[i], RR_EN ? (i % 2) : 0);
        end

        // Reset during CMD of a write: the write lands, no response
        rst_at_cmd = 1;
        q0.push_back(mk_op(8'h05, 16'h00AA, 1'b1));
        wait_idle(50);
        check_eq("rst_cmd_consumed", rst_at_cmd, 0);
        last_rd_act = 16'hDEAD;
        q1.push_back(mk_op(8'h05, 16'h0000, 1'b0));
        wait_idle(50);
        check_eq("rst_cmd_write_landed", last_rd_act, 16'h00AA);

        // Randomized traffic
        gate_mode = 0; rsp_mode = 0;
        for (int c = 0; c < 1500; c++) begin
            if (q0.size() < 2) q0.push_back(rand_op());
            if (q1.size() < 2) q1.push_back(rand_op());
            step();
        end
        wait_idle(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
